// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmitter.
// Optional parity feature is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned DefWordLength = 8;
  localparam int unsigned DefClkDiv     = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// FIFO-side handshake and serial-line signals of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned WordLength = uart_pkg::DefWordLength
);
  logic                  empty_i;
  logic [WordLength-1:0] r_data_i;
  logic                  rd_o;
  logic                  tx_o;
  logic                  busy_o;

  modport master (output empty_i, output r_data_i, input rd_o, input tx_o, input busy_o);
  modport slave  (input empty_i, input r_data_i, output rd_o, output tx_o, output busy_o);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time down-counter: bit_done_o marks the last clk_i cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned ClkDiv = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_done_o
);
  localparam int unsigned     CntW   = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = (cnt_q == '0);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter popping words from a first-word-fall-through FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WordLength = DefWordLength,
  parameter int unsigned ClkDiv     = DefClkDiv
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  uart_tx_if.slave bus
);
  localparam int unsigned     IdxW    = $clog2(WordLength);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WordLength - 1);

  tx_state_e             state_q, state_d;
  logic [WordLength-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  pop;
  logic                  bit_done;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  uart_baud_gen #(.ClkDiv(ClkDiv)) u_baud (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .restart_i  (pop),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        pop  = !bus.empty_i;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Pending word chains straight into the next start bit.
        if (bit_done) begin
          if (!bus.empty_i) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d  = S_START;
      shift_d  = bus.r_data_i;
      idx_d    = '0;
      tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^bus.r_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Reset gating keeps the pop strobe low while the FIFO already shows data.
  assign bus.rd_o   = pop & rst_ni;
  assign bus.tx_o   = tx_q;
  assign bus.busy_o = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a ClkDiv=4 instance and a ClkDiv=1 instance.
module tb_uart_tx;
  localparam int WL = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 2 + WL + P;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.WordLength(WL)) if4 ();
  uart_tx_if #(.WordLength(WL)) if1 ();

  uart_tx #(.WordLength(WL), .ClkDiv(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(if4));
  uart_tx #(.WordLength(WL), .ClkDiv(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  logic [WL-1:0] q4[$];
  logic [WL-1:0] q1[$];
  logic          tx_s[2];
  logic          rd_s[2];
  logic          busy_s[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    if4.empty_i  = (q4.size() == 0);
    if4.r_data_i = (q4.size() != 0) ? q4[0] : '0;
    if1.empty_i  = (q1.size() == 0);
    if1.r_data_i = (q1.size() != 0) ? q1[0] : '0;
  endfunction

  function automatic void push(input int i, input logic [WL-1:0] w);
    if (i == 0) q4.push_back(w);
    else        q1.push_back(w);
    drive();
  endfunction

  // Expected line level for bit slot b of a frame carrying word w.
  function automatic logic exp_bit(input logic [WL-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= WL) return w[b-1];
    if (P == 1 && b == WL + 1) return ^w;
    return 1'b1;
  endfunction

  // One clock cycle: sample at negedge, then let the FIFO model honour a pop.
  task automatic cyc();
    @(negedge clk);
    tx_s[0] = if4.tx_o; rd_s[0] = if4.rd_o; busy_s[0] = if4.busy_o;
    tx_s[1] = if1.tx_o; rd_s[1] = if1.rd_o; busy_s[1] = if1.busy_o;
    @(posedge clk);
    #1;
    if (rd_s[0] && q4.size() != 0) void'(q4.pop_front());
    if (rd_s[1] && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic pop_cycle(input int i, input string tag);
    cyc();
    check($sformatf("%s pop rd", tag), rd_s[i], 1);
    check($sformatf("%s pop tx", tag), tx_s[i], 1);
    check($sformatf("%s pop busy", tag), busy_s[i], 0);
  endtask

  task automatic idle_check(input int i, input string tag);
    cyc();
    check($sformatf("%s idle rd/tx/busy", tag), {rd_s[i], tx_s[i], busy_s[i]}, 3'b010);
  endtask

  task automatic frame(input int i, input int c, input logic [WL-1:0] w, input bit more,
                       input string tag, input int push_at = -1, input logic [WL-1:0] push_w = '0);
    for (int k = 0; k < NB * c; k++) begin
      cyc();
      check($sformatf("%s tx k=%0d", tag, k), tx_s[i], exp_bit(w, k / c));
      check($sformatf("%s busy k=%0d", tag, k), busy_s[i], 1);
      check($sformatf("%s rd k=%0d", tag, k), rd_s[i], (k == NB * c - 1) && more);
      if (k == push_at) push(i, push_w);
    end
  endtask

  initial begin
    drive();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dut4 rd/tx/busy", {if4.rd_o, if4.tx_o, if4.busy_o}, 3'b010);
    check("reset dut1 rd/tx/busy", {if1.rd_o, if1.tx_o, if1.busy_o}, 3'b010);
    rst_n = 1'b1;

    // FIFO empty for 100 cycles: nothing moves.
    for (int n = 0; n < 100; n++) begin
      cyc();
      check($sformatf("empty100 dut4 n=%0d", n), {rd_s[0], tx_s[0], busy_s[0]}, 3'b010);
      check($sformatf("empty100 dut1 n=%0d", n), {rd_s[1], tx_s[1], busy_s[1]}, 3'b010);
    end

    push(0, 8'hA5);
    pop_cycle(0, "a5");
    frame(0, 4, 8'hA5, 1'b0, "a5");
    idle_check(0, "a5");

    push(0, 8'h07);
    pop_cycle(0, "07");
    frame(0, 4, 8'h07, 1'b0, "07");
    idle_check(0, "07");

    // Back-to-back frames with no idle cycle between them.
    push(0, 8'h00);
    push(0, 8'hFF);
    pop_cycle(0, "b2b");
    frame(0, 4, 8'h00, 1'b1, "b2b 00");
    frame(0, 4, 8'hFF, 1'b0, "b2b ff");
    idle_check(0, "b2b");

    // FIFO contents change mid-frame; the frame in flight must not.
    push(0, 8'h5A);
    pop_cycle(0, "mid");
    frame(0, 4, 8'h5A, 1'b1, "mid 5a", 10, 8'h33);
    frame(0, 4, 8'h33, 1'b0, "mid 33");
    idle_check(0, "mid");

    // Reset two cycles into data bit 3 of 0xC3 (bit 3 is 0).
    push(0, 8'hC3);
    push(0, 8'h11);
    pop_cycle(0, "rst");
    repeat (4 + 3 * 4 + 2) cyc();
    check("rst before tx", if4.tx_o, 0);
    check("rst before busy", if4.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst async tx", if4.tx_o, 1);
    check("rst async busy", if4.busy_o, 0);
    check("rst async rd", if4.rd_o, 0);
    repeat (2) cyc();
    check("rst held rd", rd_s[0], 0);
    q4.delete();
    drive();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) idle_check(0, $sformatf("post-rst n=%0d", n));
    push(0, 8'h11);
    pop_cycle(0, "post-rst 11");
    frame(0, 4, 8'h11, 1'b0, "post-rst 11");
    idle_check(0, "post-rst 11");

    // One bit per cycle.
    push(1, 8'h3C);
    pop_cycle(1, "div1");
    frame(1, 1, 8'h3C, 1'b0, "div1 3c");
    idle_check(1, "div1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter WordLength, default 8, data bits per frame (range 5..16).
- REQ-002: Parameter ClkDiv, default 16, clk_i cycles per UART bit (range 1..65535).
- REQ-003: clk_i  input  1  single clock; all logic on posedge clk_i.
- REQ-004: rst_ni  input  1  asynchronous active-low reset.
- REQ-005: empty_i  input  1  upstream FIFO empty flag.
- REQ-006: r_data_i  input  WordLength  upstream FIFO head word, first-word-fall-through, valid while empty_i=0.
- REQ-007: rd_o  output  1  one-cycle pop strobe to upstream FIFO.
- REQ-008: tx_o  output  1  serial line, idle high.
- REQ-009: busy_o  output  1  high while a frame is in progress.

Function
- REQ-010: FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-026.
- REQ-011: In IDLE with empty_i=0, rd_o SHALL be 1 for exactly that cycle, r_data_i SHALL be captured in a shift register on the same edge, and next state SHALL be START.
- REQ-012: rd_o SHALL be combinational from state and empty_i, and SHALL never assert while empty_i=1.
- REQ-013: A bit counter SHALL hold each line level for exactly ClkDiv cycles; ClkDiv=1 gives one bit per cycle.
- REQ-014: START drives tx_o=0; DATA shifts out WordLength bits LSB first; STOP drives tx_o=1 for one bit time.
- REQ-015: tx_o SHALL be a registered output, with no glitches between bits.
- REQ-016: First start-bit cycle on tx_o SHALL be the cycle after rd_o=1 (latency 1).
- REQ-017: Frame length SHALL be (2+WordLength+P)*ClkDiv cycles, P=1 with parity, 0 without.
- REQ-018: In the last STOP cycle with empty_i=0, rd_o SHALL pulse and the FSM SHALL go directly to START (back-to-back, zero idle cycles); otherwise it SHALL go to IDLE.
- REQ-019: busy_o SHALL be 1 in every state except IDLE.
- REQ-020: Changes on empty_i/r_data_i mid-frame SHALL NOT affect the frame in progress.

Reset
- REQ-021: Asserting rst_ni SHALL immediately force state=IDLE, tx_o=1, busy_o=0, rd_o=0, and clear the counters and shift register.
- REQ-022: Reset mid-frame SHALL abort the frame with no further pops; the popped word is lost.
- REQ-023: After rst_ni deasserts, the first pop SHALL occur no earlier than the first clock edge with empty_i=0.

Configuration
- REQ-024: Macro UART_TX_PARITY_EN SHALL select the parity feature.
- REQ-025: Without the macro, there SHALL be no PARITY state and no parity logic.
- REQ-026: With the macro, DATA SHALL be followed by PARITY for one bit time, with tx_o = XOR of the captured data bits (even parity).

Structure
- REQ-027: Package uart_pkg SHALL hold the FSM state enum typedef and the default WordLength/ClkDiv constants.
- REQ-028: Sub-module uart_baud_gen SHALL implement the ClkDiv down-counter with a restart input and a bit_done pulse output; uart_tx SHALL instantiate it once.

Verification (WordLength=8, ClkDiv=4)
- REQ-029: FIFO holds 0xA5, parity off -> one rd_o pulse; tx_o = 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles; 40 cycles total; busy_o low afterwards.
- REQ-030: Same stimulus with UART_TX_PARITY_EN -> parity bit 0 after data; 44 cycles; then 0x07 -> parity bit 1.
- REQ-031: empty_i held at 1 for 100 cycles -> rd_o never asserts, tx_o=1, busy_o=0.
- REQ-032: FIFO holds 0x00 then 0xFF -> two rd_o pulses 40 cycles apart; 80 contiguous frame cycles; no idle high cycle between the stop bit and the second start bit.
- REQ-033: rst_ni low during data bit 3 -> tx_o=1 and busy_o=0 before the next edge; no rd_o until empty_i=0 after release.
- REQ-034: ClkDiv=1, 0x3C -> 10-cycle frame with one bit per cycle.
